// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: reset levels, FSM encoding and
// default parameter values.
package cpu_run_ctrl_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRstHold = 2'd1,
    StRun     = 2'd2,
    StDone    = 2'd3
  } run_state_e;

  localparam int unsigned PcWDefault       = 32;
  localparam int unsigned RstCyclesDefault = 4;
  localparam int unsigned MaxCyclesDefault = 90;
  localparam int unsigned HaltStableDefault = 8;
  localparam int unsigned SigRegDefault    = 31;
  localparam logic [31:0] PassValueDefault = 32'h1;

endpackage

// File: rtl/cpu_run_ctrl_halt_detector.sv
// PC-stability tracker: flags a halt when HALT_STABLE consecutive valid samples
// carry the same PC. Invalid cycles hold the tracking state.
module halt_detector #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned HALT_STABLE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [PC_W-1:0] pc,
  input  logic            pc_valid,
  output logic            halted
);

  localparam int unsigned     CntW   = $clog2(HALT_STABLE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(HALT_STABLE);

  logic [PC_W-1:0] last_pc_q, last_pc_d;
  logic [CntW-1:0] stable_cnt_q, stable_cnt_d;

  always_comb begin
    stable_cnt_d = stable_cnt_q;
    last_pc_d    = last_pc_q;
    if (pc_valid) begin
      if (pc == last_pc_q) begin
        // Saturate so a long stall cannot wrap back below the threshold.
        if (stable_cnt_q != CntMax) begin
          stable_cnt_d = stable_cnt_q + 1'b1;
        end
      end else begin
        stable_cnt_d = CntW'(1);
        last_pc_d    = pc;
      end
    end
  end

  // Combinational so the controller sees the halt in the same cycle as the final sample.
  assign halted = (stable_cnt_d == CntMax);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stable_cnt_q <= '0;
      last_pc_q    <= '0;
    end else begin
      stable_cnt_q <= stable_cnt_d;
      last_pc_q    <= last_pc_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: holds the core in reset, runs it until it halts or times
// out, and reports pass/fail from the signature register writes.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = PcWDefault,
  parameter int unsigned RST_CYCLES  = RstCyclesDefault,
  parameter int unsigned MAX_CYCLES  = MaxCyclesDefault,
  parameter int unsigned HALT_STABLE = HaltStableDefault,
  parameter int unsigned SIG_REG     = SigRegDefault,
  parameter logic [31:0] PASS_VALUE  = PassValueDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] core_pc,
  input  logic            core_pc_valid,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            core_rst,
  output logic            running,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [31:0]     cycle_count,
  output logic [31:0]     signature
);

  localparam logic [4:0]  SigAddr   = 5'(SIG_REG);
  localparam logic [31:0] HoldLast  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TimeoutAt = 32'(MAX_CYCLES - 1);

  run_state_e  state_q;
  logic [31:0] hold_cnt_q;
  logic        accept;
  logic        halted;
  logic [31:0] sig_next;
  logic        sig_ok;

  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
  // A signature write in the final RUN cycle still counts toward the verdict.
  assign sig_next = (wb_we && (wb_addr == SigAddr)) ? wb_data : signature;
  assign sig_ok   = (sig_next == PASS_VALUE);

  halt_detector #(
    .PC_W        (PC_W),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt_detector (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .pc       (core_pc),
    .pc_valid (core_pc_valid),
    .halted   (halted)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= StIdle;
      hold_cnt_q  <= '0;
      core_rst    <= RstEnable;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      signature   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StRstHold;
            hold_cnt_q  <= '0;
            core_rst    <= RstEnable;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            signature   <= '0;
          end
        end
        StRstHold: begin
          if (hold_cnt_q == HoldLast) begin
            state_q  <= StRun;
            core_rst <= RstDisable;
            running  <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 32'd1;
          end
        end
        StRun: begin
          cycle_count <= cycle_count + 32'd1;
          signature   <= sig_next;
          // Halt takes priority over a coincident timeout.
          if (halted) begin
            state_q  <= StDone;
            core_rst <= RstEnable;
            running  <= 1'b0;
            done     <= 1'b1;
            pass     <= sig_ok;
            fail     <= !sig_ok;
            timeout  <= 1'b0;
          end else if (cycle_count == TimeoutAt) begin
            state_q  <= StDone;
            core_rst <= RstEnable;
            running  <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            fail     <= 1'b1;
            timeout  <= 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          core_rst <= RstEnable;
          running  <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: reset/start timing sequences plus a table
// of run scenarios whose expected verdicts go through a scoreboard queue.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] core_pc;
  logic        core_pc_valid;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        core_rst;
  logic        running;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [31:0] cycle_count;
  logic [31:0] signature;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          hs;        // first RUN cycle at which the PC stays at 0x40
    int          gap;       // RUN cycle with core_pc_valid low (-1: none)
    int          write_at;  // RUN cycle of the register write (-1: none)
    logic [4:0]  addr;
    logic [31:0] sig;
    logic        exp_pass;
    logic        exp_timeout;
    logic [31:0] exp_cc;
    logic [31:0] exp_sig;
  } vec_t;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] cc;
    logic [31:0] sig;
  } exp_t;

  vec_t vecs[9];
  exp_t exp_q[$];

  cpu_run_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .core_pc       (core_pc),
    .core_pc_valid (core_pc_valid),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .core_rst      (core_rst),
    .running       (running),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .timeout       (timeout),
    .cycle_count   (cycle_count),
    .signature     (signature)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_clear(input string tag);
    chk({tag, "_core_rst"}, core_rst, 1);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
    chk({tag, "_signature"}, signature, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   n;
    int   k;
    e.pass    = v.exp_pass;
    e.fail    = !v.exp_pass;
    e.timeout = v.exp_timeout;
    e.cc      = v.exp_cc;
    e.sig     = v.exp_sig;
    exp_q.push_back(e);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!running && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_enter_run", idx), running, 1);
    chk($sformatf("v%0d_first_cc", idx), cycle_count, 0);
    chk($sformatf("v%0d_run_core_rst", idx), core_rst, 0);

    k = 0;
    while (running && k < 200) begin
      core_pc_valid = (k != v.gap);
      if (k == v.gap)     core_pc = 32'hdead0000;
      else if (k >= v.hs) core_pc = 32'h40;
      else                core_pc = 32'h100 + 32'(4 * k);
      wb_we   = (k == v.write_at);
      wb_addr = v.addr;
      wb_data = v.sig;
      @(negedge clk);
      k++;
    end
    core_pc_valid = 1'b0;
    wb_we         = 1'b0;

    e = exp_q.pop_front();
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_pass", idx), pass, e.pass);
    chk($sformatf("v%0d_fail", idx), fail, e.fail);
    chk($sformatf("v%0d_timeout", idx), timeout, e.timeout);
    chk($sformatf("v%0d_cycle_count", idx), cycle_count, e.cc);
    chk($sformatf("v%0d_signature", idx), signature, e.sig);
    chk($sformatf("v%0d_done_core_rst", idx), core_rst, 1);
  endtask

  initial begin
    //        hs    gap  wr  addr   sig    pass tmo  cc     sig_out
    vecs[0] = '{5,    -1,  2, 5'd31, 32'h1, 1'b1, 1'b0, 32'd13, 32'h1};
    vecs[1] = '{0,    -1, -1, 5'd31, 32'h0, 1'b0, 1'b0, 32'd8,  32'h0};
    vecs[2] = '{5,    -1,  2, 5'd31, 32'h2, 1'b0, 1'b0, 32'd13, 32'h2};
    vecs[3] = '{1000, -1,  3, 5'd31, 32'h1, 1'b0, 1'b1, 32'd90, 32'h1};
    vecs[4] = '{82,   -1,  0, 5'd31, 32'h1, 1'b1, 1'b0, 32'd90, 32'h1};
    vecs[5] = '{83,   -1,  0, 5'd31, 32'h1, 1'b0, 1'b1, 32'd90, 32'h1};
    vecs[6] = '{10,   -1, 17, 5'd31, 32'h1, 1'b1, 1'b0, 32'd18, 32'h1};
    vecs[7] = '{0,    -1,  1, 5'd30, 32'h1, 1'b0, 1'b0, 32'd8,  32'h0};
    vecs[8] = '{0,     3,  1, 5'd31, 32'h1, 1'b1, 1'b0, 32'd9,  32'h1};

    rst           = 1'b1;
    start         = 1'b0;
    core_pc       = '0;
    core_pc_valid = 1'b0;
    wb_we         = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_clear("reset");

    // Start two cycles after reset: core_rst spans the start cycle plus four hold cycles.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    chk("start_cycle_core_rst", core_rst, 1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("hold%0d_core_rst", i), core_rst, 1);
      chk($sformatf("hold%0d_running", i), running, 0);
      @(negedge clk);
    end
    chk("run_entry_running", running, 1);
    chk("run_entry_core_rst", core_rst, 0);
    chk("run_entry_cycle_count", cycle_count, 0);

    // Twenty RUN cycles with a moving PC, a signature write and a stray start.
    for (int k = 0; k < 20; k++) begin
      core_pc       = 32'h200 + 32'(4 * k);
      core_pc_valid = 1'b1;
      wb_we         = (k == 3);
      wb_addr       = 5'd31;
      wb_data       = 32'h55;
      start         = (k == 5);
      @(negedge clk);
    end
    wb_we = 1'b0;
    chk("midrun_cycle_count", cycle_count, 20);
    chk("midrun_signature", signature, 32'h55);
    chk("midrun_running", running, 1);

    // Reset at RUN cycle 20 together with start: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    start         = 1'b0;
    core_pc_valid = 1'b0;
    chk_idle_clear("midrun_rst");
    repeat (6) @(negedge clk);
    chk("post_rst_still_idle", running, 0);

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
